// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and constants for the alu_mdu execute unit.
package alu_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD   = 5'd0,
    ALU_ADDU  = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SUBU  = 5'd3,
    ALU_SLT   = 5'd4,
    ALU_SLTU  = 5'd5,
    ALU_AND   = 5'd6,
    ALU_OR    = 5'd7,
    ALU_XOR   = 5'd8,
    ALU_NOR   = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_SRL   = 5'd11,
    ALU_SRA   = 5'd12,
    ALU_LUI   = 5'd13,
    ALU_MFHI  = 5'd14,
    ALU_MFLO  = 5'd15,
    ALU_MULT  = 5'd16,
    ALU_MULTU = 5'd17,
    ALU_DIV   = 5'd18,
    ALU_DIVU  = 5'd19,
    ALU_MTHI  = 5'd20,
    ALU_MTLO  = 5'd21
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_HOLD
  } alu_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0;

endpackage

// File: rtl/alu_divider.sv
// Restoring divider: one quotient bit per cycle, then one sign-fix cycle.
module alu_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    D_IDLE,
    D_RUN,
    D_FIX
  } div_state_e;

  div_state_e        st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;

  logic              a_neg, b_neg, ge;
  logic [DATA_W:0]   shifted, diff;

  assign a_neg   = signed_i & a_i[DATA_W-1];
  assign b_neg   = signed_i & b_i[DATA_W-1];
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = shifted >= {1'b0, dvs_q};

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    unique case (st_q)
      D_IDLE: begin
        if (start_i) begin
          st_d   = D_RUN;
          cnt_d  = CW'(DATA_W - 1);
          rem_d  = '0;
          quo_d  = a_neg ? -a_i : a_i;
          dvs_d  = b_neg ? -b_i : b_i;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dz_d   = (b_i == '0);
        end
      end
      D_RUN: begin
        rem_d = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) st_d = D_FIX;
      end
      D_FIX:   st_d = D_IDLE;
      default: st_d = D_IDLE;
    endcase
    if (abort_i) st_d = D_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= D_IDLE;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  // Divide-by-zero keeps the remainder path: |a| negated back gives a.
  assign busy_o = (st_q != D_IDLE);
  assign done_o = (st_q == D_FIX);
  assign quo_o  = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign rem_o  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execute unit: registered ALU, pipelined multiplier and
// iterative divider feeding HI/LO, behind a valid/ready handshake.
module alu_mdu #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3,
  parameter int OP_W    = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] da,
  input  logic [DATA_W-1:0] db,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  import alu_pkg::*;

  localparam int SW  = $clog2(DATA_W);
  localparam int MCW = $clog2(MUL_LAT + 1);
  localparam int PW  = 2 * DATA_W;

  alu_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [MCW-1:0]    mcnt_q, mcnt_d;
  logic [PW-1:0]     prod_q [MUL_LAT];

  logic              accept, is_sub, is_mul, is_div;
  logic              add_ovf, alu_ovf;
  logic [DATA_W-1:0] b_eff, alu_res, sra_res;
  logic [DATA_W:0]   sum;
  logic [SW-1:0]     shamt;
  logic [PW-1:0]     ext_a, ext_b, prod;
  logic              div_start, div_busy, div_done;
  logic [DATA_W-1:0] div_quo, div_rem;

  assign in_ready = (state_q == ST_IDLE)
                 || (state_q == ST_HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  assign is_mul = (op == ALU_MULT) || (op == ALU_MULTU);
  assign is_div = (op == ALU_DIV) || (op == ALU_DIVU);
  assign is_sub = (op == ALU_SUB) || (op == ALU_SUBU)
               || (op == ALU_SLT) || (op == ALU_SLTU);

  // One adder serves add, sub and both compares.
  assign b_eff   = is_sub ? ~db : db;
  assign sum     = {1'b0, da} + {1'b0, b_eff}
                 + {{DATA_W{1'b0}}, is_sub};
  assign add_ovf = (da[DATA_W-1] == b_eff[DATA_W-1])
                && (sum[DATA_W-1] != da[DATA_W-1]);
  assign shamt   = da[SW-1:0];
  assign sra_res = $signed(db) >>> shamt;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        alu_res = sum[DATA_W-1:0];
        alu_ovf = add_ovf;
      end
      ALU_ADDU, ALU_SUBU: alu_res = sum[DATA_W-1:0];
      ALU_SLT:
        alu_res = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ add_ovf};
      ALU_SLTU:
        alu_res = {{(DATA_W-1){1'b0}}, ~sum[DATA_W]};
      ALU_AND:  alu_res = da & db;
      ALU_OR:   alu_res = da | db;
      ALU_XOR:  alu_res = da ^ db;
      ALU_NOR:  alu_res = ~(da | db);
      ALU_SLL:  alu_res = db << shamt;
      ALU_SRL:  alu_res = db >> shamt;
      ALU_SRA:  alu_res = sra_res;
      ALU_LUI:
        alu_res = {db[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  assign ext_a = (op == ALU_MULT) ? {{DATA_W{da[DATA_W-1]}}, da}
                                  : {{DATA_W{1'b0}}, da};
  assign ext_b = (op == ALU_MULT) ? {{DATA_W{db[DATA_W-1]}}, db}
                                  : {{DATA_W{1'b0}}, db};
  assign prod  = ext_a * ext_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else begin
      prod_q[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign div_start = accept && is_div && !flush;

  alu_divider #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (div_start),
    .signed_i (op == ALU_DIV),
    .abort_i  (flush),
    .a_i      (da),
    .b_i      (db),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .quo_o    (div_quo),
    .rem_o    (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcnt_d      = mcnt_q;
    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (state_q == ST_HOLD && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (accept) begin
          result_d    = DATA_W'(ZERO_WORD);
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
          unique case (1'b1)
            is_mul: begin
              out_valid_d = 1'b0;
              state_d     = ST_MUL;
              mcnt_d      = MCW'(MUL_LAT - 1);
            end
            is_div: begin
              out_valid_d = 1'b0;
              state_d     = ST_DIV;
            end
            (op == ALU_MTHI): hi_d = da;
            (op == ALU_MTLO): lo_d = da;
            default: begin
              result_d = alu_res;
              ovf_d    = alu_ovf;
            end
          endcase
        end
      end
      ST_MUL: begin
        mcnt_d = mcnt_q - MCW'(1);
        if (mcnt_q == '0) begin
          {hi_d, lo_d} = prod_q[MUL_LAT-1];
          result_d     = DATA_W'(ZERO_WORD);
          ovf_d        = 1'b0;
          out_valid_d  = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          hi_d        = div_rem;
          lo_d        = div_quo;
          result_d    = DATA_W'(ZERO_WORD);
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (!div_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush discards anything accepted or completing this cycle.
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      ovf_d       = ovf_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      mcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu with hand-computed expectations.
module tb_alu_mdu;

  import alu_pkg::*;

  localparam int W  = 32;
  localparam int ML = 3;

  logic         clk = 1'b0;
  logic         rst, in_valid, flush, out_ready;
  logic [4:0]   op;
  logic [W-1:0] da, db;
  logic         in_ready, out_valid, ovf;
  logic [W-1:0] result, hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mdu #(.DATA_W(W), .MUL_LAT(ML), .OP_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .da        (da),
    .db        (db),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .hi        (hi),
    .lo        (lo)
  );

  // Called at a negedge; returns at the next negedge.
  task automatic issue(input logic [4:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    op = o; da = a; db = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; da = '0; db = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0 || ovf !== 1'b0) begin errors++;
      $display("FAIL reset_result: got %h/%b want 0/0", result, ovf); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
  endtask

  task automatic test_add_sub;
    issue(ALU_ADD, 32'h7FFFFFFF, 32'h1);
    checks++; if (out_valid !== 1'b1 || result !== 32'h80000000
                  || ovf !== 1'b1) begin errors++;
      $display("FAIL add_ovf: got v=%b %h o=%b want 1 80000000 1",
               out_valid, result, ovf); end
    issue(ALU_ADDU, 32'h7FFFFFFF, 32'h1);
    checks++; if (result !== 32'h80000000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL addu: got %h o=%b want 80000000 0", result, ovf); end
    issue(ALU_SUB, 32'd5, 32'd7);
    checks++; if (result !== 32'hFFFFFFFE || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub: got %h o=%b want FFFFFFFE 0", result, ovf); end
    issue(ALU_SUB, 32'h80000000, 32'h1);
    checks++; if (result !== 32'h7FFFFFFF || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: got %h o=%b want 7FFFFFFF 1", result, ovf);
    end
  endtask

  task automatic test_logic_shift;
    logic [4:0]   ops [12] = '{ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SRL,
                               ALU_SLL, ALU_LUI, ALU_AND, ALU_OR,
                               ALU_XOR, ALU_NOR, ALU_SUBU, 5'd31};
    logic [W-1:0] va  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd4,
                               32'd33, 32'h0, 32'hF0F0F0F0,
                               32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'hF0F0F0F0, 32'h0, 32'h12345678};
    logic [W-1:0] vb  [12] = '{32'h1, 32'h1, 32'h80000000, 32'h80000000,
                               32'h1, 32'h1234, 32'hFF00FF00,
                               32'hFF00FF00, 32'hFF00FF00,
                               32'hFF00FF00, 32'h1, 32'h9ABCDEF0};
    logic [W-1:0] exp [12] = '{32'h1, 32'h0, 32'hF8000000, 32'h08000000,
                               32'h2, 32'h12340000, 32'hF000F000,
                               32'hFFF0FFF0, 32'h0FF00FF0,
                               32'h000F000F, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], va[i], vb[i]);
      checks++;
      if (out_valid !== 1'b1 || result !== exp[i] || ovf !== 1'b0) begin
        errors++;
        $display("FAIL alu_vec%0d op=%0d: got v=%b %h o=%b want 1 %h 0",
                 i, ops[i], out_valid, result, ovf, exp[i]);
      end
    end
  endtask

  task automatic test_mult;
    int n;
    issue(ALU_MULT, 32'hFFFFFFFD, 32'd7);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      checks++; if (in_ready !== 1'b0) begin errors++;
        $display("FAIL mult_busy_ready: cycle %0d got %b want 0",
                 n, in_ready); end
      @(negedge clk); n++;
    end
    checks++; if (n !== ML) begin errors++;
      $display("FAIL mult_latency: got %0d want %0d", n, ML); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB
                  || result !== 32'h0) begin errors++;
      $display("FAIL mult_hilo: got %h %h r=%h want FFFFFFFF FFFFFFEB 0",
               hi, lo, result); end
    issue(ALU_MFLO, 32'h0, 32'h0);
    checks++; if (result !== 32'hFFFFFFEB) begin errors++;
      $display("FAIL mflo: got %h want FFFFFFEB", result); end
    issue(ALU_MFHI, 32'h0, 32'h0);
    checks++; if (result !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL mfhi: got %h want FFFFFFFF", result); end
    issue(ALU_MULTU, 32'hFFFFFFFF, 32'd2);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n !== ML || hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu: got n=%0d %h %h want %0d 1 FFFFFFFE",
               n, hi, lo, ML); end
  endtask

  task automatic test_div;
    logic [4:0]   ops [6] = '{ALU_DIV, ALU_DIVU, ALU_DIV, ALU_DIV,
                              ALU_DIV, ALU_DIVU};
    logic [W-1:0] va  [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7,
                              32'hFFFFFFF9, 32'd100};
    logic [W-1:0] vb  [6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE,
                              32'd0, 32'd7};
    logic [W-1:0] elo [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
    logic [W-1:0] ehi [6] = '{32'hFFFFFFFF, 32'd7, 32'h0, 32'd1,
                              32'hFFFFFFF9, 32'd2};
    int n;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], va[i], vb[i]);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
        @(negedge clk); n++;
      end
      checks++;
      if (n !== W + 1 || lo !== elo[i] || hi !== ehi[i]
          || ovf !== 1'b0 || result !== 32'h0) begin
        errors++;
        $display("FAIL div_vec%0d: got n=%0d lo=%h hi=%h o=%b want %0d %h %h 0",
                 i, n, lo, hi, ovf, W + 1, elo[i], ehi[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(ALU_ADD, 32'd1, 32'd2);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd3) begin errors++;
      $display("FAIL hold_first: got v=%b %h want 1 3", out_valid, result);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b %h rdy=%b want 1 3 0",
                 i, out_valid, result, in_ready);
      end
    end
    out_ready = 1'b1;
    op = ALU_ADD; da = 32'd10; db = 32'd20; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL hold_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++;
      $display("FAIL b2b_result: got v=%b %h want 1 1E", out_valid, result);
    end
  endtask

  task automatic test_flush;
    logic seen;
    issue(ALU_MTHI, 32'hA5, 32'h0);
    checks++; if (out_valid !== 1'b1 || result !== 32'h0
                  || hi !== 32'hA5) begin errors++;
      $display("FAIL mthi: got v=%b r=%h hi=%h want 1 0 A5",
               out_valid, result, hi); end
    issue(ALU_MFHI, 32'h0, 32'h0);
    checks++; if (result !== 32'hA5) begin errors++;
      $display("FAIL mfhi_after_mthi: got %h want A5", result); end
    issue(ALU_DIV, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_state: got rdy=%b v=%b want 1 0",
               in_ready, out_valid); end
    checks++; if (hi !== 32'hA5 || lo !== 32'd14) begin errors++;
      $display("FAIL flush_hilo: got %h %h want A5 E", hi, lo); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || hi !== 32'hA5) begin errors++;
      $display("FAIL flush_no_commit: got seen=%b hi=%h want 0 A5",
               seen, hi); end
    op = ALU_MTLO; da = 32'h55; db = 32'h0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (lo !== 32'd14 || out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_accept: got lo=%h v=%b want E 0", lo, out_valid);
    end
  endtask

  task automatic test_rst_mid;
    logic seen;
    issue(ALU_MULT, 32'd3, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mid_state: got rdy=%b v=%b want 1 0",
               in_ready, out_valid); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || result !== 32'h0
                  || ovf !== 1'b0) begin errors++;
      $display("FAIL rst_mid_regs: got %h %h %h %b want 0 0 0 0",
               hi, lo, result, ovf); end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || lo !== 32'h0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL rst_mid_commit: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mult();
    test_div();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
